// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver; byte out one clk after the mid-stop-bit tick, no backpressure.
// Optional even-parity bit between data and stop when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic       i_rx,
  output logic [7:0] o_data_out,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_armed;
  logic [7:0]    r_data_out;
  logic          r_valid;
  logic          r_frame_err;
  logic          w_mid;
  logic          w_end;
  logic          w_cnt_clr;
  logic          w_cnt_inc;
  logic          w_shift;
  logic          w_deliver;
  logic          w_busy;

  assign w_mid = (r_cnt == CNT_MID);
  assign w_end = (r_cnt == CNT_END);

  // The line is asynchronous; idle-high reset value keeps a reset from looking like a start edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_tick && !r_rx_s && r_armed) w_next = S_START;
      S_START: if (i_tick && w_mid) w_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (i_tick && w_end && (r_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          w_next = S_PARITY;
`else
          w_next = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (i_tick && w_end) w_next = S_STOP;
`endif
      S_STOP:  if (i_tick && w_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_cnt_clr = 1'b0;
    w_shift   = 1'b0;
    w_deliver = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = i_tick;
      S_START: w_cnt_clr = i_tick && w_mid;
      S_DATA: begin
        w_cnt_clr = i_tick && w_end;
        w_shift   = i_tick && w_end;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: w_cnt_clr = i_tick && w_end;
`endif
      S_STOP: begin
        w_cnt_clr = i_tick && w_end;
        w_deliver = i_tick && w_end;
      end
      default: w_cnt_clr = 1'b1;
    endcase
    w_cnt_inc = i_tick && !w_cnt_clr && w_busy;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else if (r_state == S_IDLE) begin
      r_idx   <= 3'd0;
    end else if (w_shift) begin
      r_idx   <= r_idx + 3'd1;
      r_shift <= {r_rx_s, r_shift[7:1]};
    end
  end

  // A low stop bit disarms start detection until the line is seen high, so a break yields one frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_armed <= 1'b1;
    end else if (w_deliver) begin
      r_armed <= r_rx_s;
    end else if ((r_state == S_IDLE) && i_tick && r_rx_s) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out  <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= w_deliver;
      r_frame_err <= w_deliver && !r_rx_s;
      if (w_deliver) r_data_out <= r_shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && i_tick && w_end) r_par_bit <= r_rx_s;
      r_parity_err <= w_deliver && (^{r_shift, r_par_bit});
    end
  end

  assign o_parity_err = r_parity_err;
`else
  assign o_parity_err = 1'b0;
`endif

  assign o_data_out  = r_data_out;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_busy      = w_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: OVERSAMPLE=16, tick every 4 clk, 64 clk per bit.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_tick      (tick),
    .i_rx        (rx),
    .o_data_out  (data_out),
    .o_valid     (valid),
    .o_frame_err (frame_err),
    .o_parity_err(parity_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clk(BIT_CLK);
  endtask

  // par is the transmitted parity bit; only placed on the line in parity builds.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("parity bit undefined");
`endif
    send_bit(stop);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.pe = pe;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: data 0x%02h fe %0b, no byte expected at %0t", data_out, frame_err, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("data_out", data_out, e.d);
        check("frame_err", {7'd0, frame_err}, {7'd0, e.fe});
        check("parity_err", {7'd0, parity_err}, {7'd0, e.pe});
      end
    end
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(3);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_frame_err", {7'd0, frame_err}, 8'd0);
    check("rst_parity_err", {7'd0, parity_err}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    rst = 1'b0;
    wait_clk(BIT_CLK);

    // Nominal frame with busy observed mid-frame and after.
    expect_byte(8'hA5, 1'b0, 1'b0);
    fork
      send_frame(8'hA5, 1'b1, ^8'hA5);
      begin
        wait_clk(3 * BIT_CLK);
        check("busy_mid_frame", {7'd0, busy}, 8'd1);
      end
    join
    wait_clk(BIT_CLK);
    check("busy_after_frame", {7'd0, busy}, 8'd0);

    // Start glitch of 3 ticks is rejected at mid-bit.
    rx = 1'b0;
    wait_clk(12);
    rx = 1'b1;
    wait_clk(48);
    check("busy_after_glitch", {7'd0, busy}, 8'd0);
    wait_clk(BIT_CLK);

    // Framing error followed by a held-low break.
    expect_byte(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    wait_clk(BIT_CLK);
    check("busy_during_break", {7'd0, busy}, 8'd0);
    wait_clk(2 * BIT_CLK);
    rx = 1'b1;
    wait_clk(2 * BIT_CLK);
    expect_byte(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, ^8'h11);
    wait_clk(BIT_CLK);

    // Back-to-back frames with no idle gap.
    expect_byte(8'h00, 1'b0, 1'b0);
    expect_byte(8'hFF, 1'b0, 1'b0);
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    wait_clk(BIT_CLK);

    // Reset in the middle of 0x77 aborts it.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h77 >> i));
    check("busy_before_rst", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("abort_data_out", data_out, 8'h00);
    check("abort_valid", {7'd0, valid}, 8'd0);
    check("abort_frame_err", {7'd0, frame_err}, 8'd0);
    check("abort_parity_err", {7'd0, parity_err}, 8'd0);
    check("abort_busy", {7'd0, busy}, 8'd0);
    wait_clk(2 * BIT_CLK);
    expect_byte(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    wait_clk(BIT_CLK);

`ifdef UART_RX_PARITY_EN
    expect_byte(8'h01, 1'b0, 1'b1);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_clk(BIT_CLK);
    expect_byte(8'h01, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b1);
    wait_clk(BIT_CLK);
`endif

    check("pending_bytes", 8'(sb_q.size()), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
